// File: rtl/ram_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_dp: simple dual-port byte-writable RAM with a self-clearing sequence. |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module ram_dp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                wena,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                rena,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic                clr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int BE_W  = DATA_W/8;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cnt, cnt_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept, wr_en, rd_en;
  logic [DATA_W-1:0]   rd_word;

  // clr wins over same-cycle reads and writes
  always_comb begin
    accept = (state == READY) && ena && !clr;
    wr_en  = accept && wena;
    rd_en  = accept && rena;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH-1)) state_next = READY;
      end
      READY: begin
        if (ena && clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_word;
    end
  end

  // Array has no reset; it is zeroed only by walking cnt in CLEAR
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Write-first bypass for enabled lanes on a same-address collision
  always_comb begin
    rd_word = mem[raddr];
    if (wr_en && (waddr == raddr)) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  assign busy = (state == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_ram_dp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_dp: randomized and directed self-checking bench for ram_dp.       |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ram_dp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0, wena = 1'b0, rena = 1'b0, clr = 1'b0;
  logic [4:0]  waddr = '0, raddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] rdata;
  logic        rvalid, busy;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  ram_dp #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ena(ena), .wena(wena), .waddr(waddr),
    .wdata(wdata), .wbe(wbe), .rena(rena), .raddr(raddr), .clr(clr),
    .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: a clear is just a countdown, after which the whole array is zero
  logic [31:0] m_mem [32];
  int          m_busy_left = 32;
  logic [31:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy_left = 32;
      m_rdata     = '0;
      m_rvalid    = 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left = m_busy_left - 1;
      m_rvalid    = 1'b0;
      if (m_busy_left == 0)
        for (int a = 0; a < 32; a++) m_mem[a] = '0;
    end else if (ena && clr) begin
      m_busy_left = 32;
      m_rvalid    = 1'b0;
    end else if (ena) begin
      if (wena)
        for (int b = 0; b < 4; b++)
          if (wbe[b]) m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
      if (rena) m_rdata = m_mem[raddr];
      m_rvalid = rena;
    end else begin
      m_rvalid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (busy !== (m_busy_left > 0)) begin
        errors++;
        $display("FAIL busy t=%0t: got %b expected %b", $time, busy, (m_busy_left > 0));
      end
      checks++;
      if (rvalid !== m_rvalid) begin
        errors++;
        $display("FAIL rvalid t=%0t: got %b expected %b", $time, rvalid, m_rvalid);
      end
      checks++;
      if (rdata !== m_rdata) begin
        errors++;
        $display("FAIL rdata t=%0t: got %h expected %h", $time, rdata, m_rdata);
      end
    end
  end

  task automatic drive(input logic e, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic re, input logic [4:0] ra, input logic c);
    @(posedge clk);
    #2;
    ena = e; wena = we; waddr = wa; wdata = wd; wbe = be;
    rena = re; raddr = ra; clr = c;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_lit(input string name, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [4:0] a,
                            input logic [31:0] exp);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, a, 1'b0);
    idle();
    check_lit({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check_lit(name, rdata, exp);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      idle();
    end
  endtask

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    cmp_on = 1'b1;
    check_lit("reset_rdata", rdata, 32'd0);
    check_lit("reset_rvalid", {31'd0, rvalid}, 32'd0);
    check_lit("reset_busy", {31'd0, busy}, 32'd1);

    rst = 1'b0;
    count_busy(n);
    check_lit("busy_after_reset", n, 32);
    read_check("rd_1f_zero", 5'h1F, 32'h0);

    drive(1'b1, 1'b1, 5'h00, 32'h12345678, 4'hF, 1'b0, 5'd0, 1'b0);
    read_check("rd_00_full", 5'h00, 32'h12345678);

    drive(1'b1, 1'b1, 5'h01, 32'hA5A5A5A5, 4'hF, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b1, 5'h01, 32'h0000FF00, 4'b0010, 1'b0, 5'd0, 1'b0);
    read_check("rd_01_partial", 5'h01, 32'hA5A5FFA5);

    drive(1'b1, 1'b1, 5'h1B, 32'h77777777, 4'b0011, 1'b1, 5'h1B, 1'b0);
    idle();
    check_lit("wf_rvalid", {31'd0, rvalid}, 32'd1);
    check_lit("wf_rdata", rdata, 32'h00007777);
    read_check("rd_1b_later", 5'h1B, 32'h00007777);

    drive(1'b0, 1'b1, 5'h00, 32'hDEADBEEF, 4'hF, 1'b1, 5'h00, 1'b0);
    idle();
    check_lit("ena0_rvalid", {31'd0, rvalid}, 32'd0);
    read_check("rd_00_after_ena0", 5'h00, 32'h12345678);

    drive(1'b1, 1'b1, 5'h02, 32'h11111111, 4'hF, 1'b1, 5'h00, 1'b1);
    idle();
    count_busy(n);
    check_lit("busy_after_clr", n, 32);
    read_check("clr_rd_00", 5'h00, 32'h0);
    read_check("clr_rd_01", 5'h01, 32'h0);
    read_check("clr_rd_1b", 5'h1B, 32'h0);

    drive(1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b1);
    idle();
    repeat (10) idle();
    rst = 1'b1;
    idle();
    check_lit("midclr_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    count_busy(n);
    check_lit("busy_after_midclr_rst", n, 32);

    drive(1'b1, 1'b1, 5'h05, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'h05, 1'b0);
    rst = 1'b1;
    #1;
    check_lit("rst_inflight_rvalid", {31'd0, rvalid}, 32'd0);
    idle();
    check_lit("rst_inflight_rvalid2", {31'd0, rvalid}, 32'd0);
    rst = 1'b0;
    count_busy(n);

    for (int k = 0; k < 3000; k++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 7) != 0),
            1'($urandom),
            wa,
            $urandom,
            4'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 99) == 0));
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        idle();
        rst = 1'b0;
      end
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
